// File: rtl/apu_env_pkg.sv
// Shared field positions and channel indices for the APU envelope bank.
// The hold/from_cpu word is {loop/halt, constant, period/volume}.
package apu_env_pkg;

  localparam int VOL_W_DEF = 4;

  // Field positions for the default 4-bit volume width
  localparam int LOOP_BIT  = VOL_W_DEF + 1;
  localparam int CONST_BIT = VOL_W_DEF;
  localparam int PERIOD_HI = VOL_W_DEF - 1;
  localparam int PERIOD_LO = 0;

  // Default channel assignment
  localparam int CH_PULSE1 = 0;
  localparam int CH_PULSE2 = 1;
  localparam int CH_NOISE  = 2;

  // Field positions for an arbitrary volume width
  function automatic int loop_bit(input int vol_w);
    return vol_w + 1;
  endfunction

  function automatic int const_bit(input int vol_w);
    return vol_w;
  endfunction

endpackage

// File: rtl/apu_env_channel.sv
// One envelope unit: hold register, start flag, divider and decay counter.
// Volume and done flags are combinational from the registers.
module apu_env_channel
  import apu_env_pkg::*;
#(
  parameter int VOL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             wr,
  input  logic [VOL_W+1:0] din,
  input  logic             restart,
  output logic [VOL_W-1:0] vol,
  output logic             done
);

  localparam int LB = loop_bit(VOL_W);
  localparam int CB = const_bit(VOL_W);
  localparam logic [VOL_W-1:0] MAX = '1;

  logic [VOL_W+1:0] hold;
  logic             start;
  logic [VOL_W-1:0] divider;
  logic [VOL_W-1:0] count;
  logic [VOL_W-1:0] period;
  logic             loop_f;
  logic             const_f;

  assign period  = hold[VOL_W-1:0];
  assign loop_f  = hold[LB];
  assign const_f = hold[CB];

  // Register write: hold only changes on a write, reloads read the pre-edge value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (wr) begin
      hold <= din;
    end
  end

  // Start flag: restart wins over the clear performed by a quarter-frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start <= 1'b0;
    end else if (restart) begin
      start <= 1'b1;
    end else if (clk_en) begin
      start <= 1'b0;
    end
  end

  // Divider and decay counter advance once per quarter-frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divider <= '0;
      count   <= '0;
    end else if (clk_en) begin
      if (start) begin
        count   <= MAX;
        divider <= period;
      end else if (divider == '0) begin
        divider <= period;
        if (count != '0) begin
          count <= count - 1'b1;
        end else if (loop_f) begin
          count <= MAX;
        end
      end else begin
        divider <= divider - 1'b1;
      end
    end
  end

  assign vol  = const_f ? period : count;
  assign done = (count == '0) & ~loop_f;

endmodule

// File: rtl/apu_envelope_bank.sv
// Multi-channel APU envelope generator: shared CPU write port and
// quarter-frame enable, one apu_env_channel per channel.
// Optional feature macro: APU_ENV_MUTE_EN adds a per-channel mute input
// that forces the channel volume to zero while state keeps advancing.
module apu_envelope_bank
  import apu_env_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int VOL_W  = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [VOL_W+1:0]        from_cpu,
  input  logic                    env_wren,
  input  logic [NUM_CH-1:0]       env_restart,
`ifdef APU_ENV_MUTE_EN
  input  logic [NUM_CH-1:0]       mute,
`endif
  output logic [NUM_CH*VOL_W-1:0] env_out,
  output logic [NUM_CH-1:0]       env_done
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             wr;
    logic [VOL_W-1:0] vol;

    // Out-of-range channel indices match no channel, so the write is dropped
    assign wr = env_wren & (wr_ch == CH_W'(i));

    apu_env_channel #(
      .VOL_W (VOL_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .clk_en  (clk_en),
      .wr      (wr),
      .din     (from_cpu),
      .restart (env_restart[i]),
      .vol     (vol),
      .done    (env_done[i])
    );

`ifdef APU_ENV_MUTE_EN
    assign env_out[i*VOL_W +: VOL_W] = mute[i] ? '0 : vol;
`else
    assign env_out[i*VOL_W +: VOL_W] = vol;
`endif
  end

endmodule
